// File: rtl/bp_pkg.sv
// bp_pkg
// Shared definitions for the branch resolution stage and its branch target table:
//   - branch flag encodings carried in the A/D pipeline latch
//   - 2-bit predictor counter constants
//   - resolve-stage state enum (RUN / SQUASH)
//   - saturating counter update helper
package bp_pkg;

  // Branch flag encodings produced by decode
  localparam logic [1:0] FLAG_NONE      = 2'b00;
  localparam logic [1:0] FLAG_TAKEN     = 2'b01;
  localparam logic [1:0] FLAG_NOT_TAKEN = 2'b10;
  localparam logic [1:0] FLAG_JUMP      = 2'b11;

  // Two-bit predictor counter values (strongly/weakly not-taken/taken)
  localparam logic [1:0] CNT_SNT   = 2'b00;
  localparam logic [1:0] CNT_WNT   = 2'b01;
  localparam logic [1:0] CNT_WT    = 2'b10;
  localparam logic [1:0] CNT_ST    = 2'b11;
  localparam logic [1:0] CNT_ALLOC = CNT_WT;
  localparam logic [1:0] CNT_RESET = CNT_WNT;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } bru_state_e;

  // Saturating step of the counter toward the resolved direction
  function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) res = (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else       res = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if
// Bundles the resolve-stage record inputs, the fetch lookup port and the
// flush/redirect/statistics outputs.
//   master : pipeline side (drives the record and lookup_pc, observes results)
//   slave  : branch_resolve_unit
interface branch_resolve_unit_if;
  logic        stg_ena;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic [1:0]  in_flag;
  logic [1:0]  in_counter;
  logic        in_valid;
  logic        in_prediction;
  logic [31:0] lookup_pc;
  logic        lookup_valid;
  logic [1:0]  lookup_counter;
  logic [31:0] lookup_target;
  logic        lookup_prediction;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_count;

  modport master (
    output stg_ena, in_pc, in_target, in_flag, in_counter, in_valid, in_prediction, lookup_pc,
    input  lookup_valid, lookup_counter, lookup_target, lookup_prediction,
           flush, redirect_pc, mispredict_count
  );

  modport slave (
    input  stg_ena, in_pc, in_target, in_flag, in_counter, in_valid, in_prediction, lookup_pc,
    output lookup_valid, lookup_counter, lookup_target, lookup_prediction,
           flush, redirect_pc, mispredict_count
  );
endinterface

// File: rtl/bp_table.sv
// bp_table
// Direct-mapped branch target table. One synchronous write port, one
// combinational read port with tag compare. No write-to-read bypass: a read
// in the same cycle as a write to that index sees the old contents.
// Ports:
//   stg_clk, reset        clock, asynchronous active-low reset
//   wr_en/idx/tag/cnt/tgt write port (valid is set on every write)
//   rd_idx/rd_tag         read address
//   rd_hit                entry valid and tag match
//   rd_cnt/rd_tgt         stored counter/target of the indexed entry
module bp_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic              stg_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [29-IDX_W:0] wr_tag,
  input  logic [1:0]        wr_cnt,
  input  logic [31:0]       wr_tgt,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [29-IDX_W:0] rd_tag,
  output logic              rd_hit,
  output logic [1:0]        rd_cnt,
  output logic [31:0]       rd_tgt
);
  localparam int ENTRIES = 2 ** IDX_W;

  logic              r_valid [ENTRIES];
  logic [29-IDX_W:0] r_tag   [ENTRIES];
  logic [1:0]        r_cnt   [ENTRIES];
  logic [31:0]       r_tgt   [ENTRIES];

  // Entry storage: reset clears every entry to invalid with a weakly
  // not-taken counter; afterwards a single entry is rewritten per cycle.
  always_ff @(posedge stg_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_cnt[i]   <= CNT_RESET;
        r_tgt[i]   <= '0;
      end
    end else if (wr_en) begin
      r_valid[wr_idx] <= 1'b1;
      r_tag[wr_idx]   <= wr_tag;
      r_cnt[wr_idx]   <= wr_cnt;
      r_tgt[wr_idx]   <= wr_tgt;
    end
  end

  // Combinational read for fetch; counter/target are returned even on a
  // miss so fetch can see the raw entry.
  assign rd_hit = r_valid[rd_idx] && (r_tag[rd_idx] == rd_tag);
  assign rd_cnt = r_cnt[rd_idx];
  assign rd_tgt = r_tgt[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves the branch record from the A/D latch, pulses flush with the
// correct redirect PC on a misprediction, counts mispredictions (saturating)
// and writes the updated predictor state into bp_table. After a flush the
// next FLUSH_DEPTH stage-enabled records are wrong-path and are squashed.
// Ports:
//   stg_clk  stage clock (rising edge)
//   reset    asynchronous active-low reset
//   bus      branch_resolve_unit_if.slave: record in, lookup port,
//            flush/redirect_pc/mispredict_count out
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int IDX_W       = 4,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                 stg_clk,
  input  logic                 reset,
  branch_resolve_unit_if.slave bus
);
  localparam int CNT_W = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);
  localparam logic [CNT_W-1:0] SQ_LOAD = CNT_W'(FLUSH_DEPTH);
  localparam logic [CNT_W-1:0] SQ_ONE  = CNT_W'(1);

  bru_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_sq_cnt, w_sq_cnt_nxt;
  logic             r_flush;
  logic [31:0]      r_redirect;
  logic [15:0]      r_mcount;

  logic             w_live, w_actual, w_pred, w_mispredict, w_wr_en;
  logic [1:0]       w_wr_cnt;
  logic [31:0]      w_redirect;
  logic             w_rd_hit;
  logic [1:0]       w_rd_cnt;
  logic [31:0]      w_rd_tgt;
  logic             w_unused_lookup;

  // Byte-offset bits of the fetch PC never address the table
  assign w_unused_lookup = ^bus.lookup_pc[1:0];

  // State register: squash countdown survives stalls and is cleared by reset
  always_ff @(posedge stg_clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RUN;
      r_sq_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_cnt_nxt;
    end
  end

  // Next state: a mispredict arms the squash window; each enabled cycle in
  // SQUASH burns one wrong-path slot regardless of the record's flag.
  always_comb begin
    w_state_nxt  = r_state;
    w_sq_cnt_nxt = r_sq_cnt;
    case (r_state)
      RUN: begin
        if (w_mispredict && (FLUSH_DEPTH != 0)) begin
          w_state_nxt  = SQUASH;
          w_sq_cnt_nxt = SQ_LOAD;
        end
      end
      SQUASH: begin
        if (bus.stg_ena) begin
          if (r_sq_cnt <= SQ_ONE) begin
            w_state_nxt  = RUN;
            w_sq_cnt_nxt = '0;
          end else begin
            w_sq_cnt_nxt = r_sq_cnt - SQ_ONE;
          end
        end
      end
      default: begin
        w_state_nxt  = RUN;
        w_sq_cnt_nxt = '0;
      end
    endcase
  end

  // Resolution: the counter update uses the counter carried from fetch, not
  // the current table contents, so older in-flight updates can be overwritten.
  always_comb begin
    w_live       = bus.stg_ena && (bus.in_flag != FLAG_NONE) && (r_state == RUN);
    w_actual     = (bus.in_flag == FLAG_TAKEN) || (bus.in_flag == FLAG_JUMP);
    w_pred       = bus.in_valid && bus.in_prediction;
    w_mispredict = w_live && (w_pred != w_actual);
    w_wr_en      = w_live && (bus.in_valid || w_actual);
    w_redirect   = w_actual ? bus.in_target : bus.in_pc + 32'd4;
    if (bus.in_flag == FLAG_JUMP)
      w_wr_cnt = CNT_ST;
    else if (bus.in_valid)
      w_wr_cnt = cnt_update(bus.in_counter, w_actual);
    else
      w_wr_cnt = CNT_ALLOC;
  end

  // Registered outputs: flush is a single-cycle pulse; redirect_pc keeps the
  // last redirect; the statistics counter sticks at all-ones.
  always_ff @(posedge stg_clk or negedge reset) begin
    if (!reset) begin
      r_flush    <= 1'b0;
      r_redirect <= '0;
      r_mcount   <= '0;
    end else begin
      r_flush <= w_mispredict;
      if (w_mispredict) begin
        r_redirect <= w_redirect;
        if (r_mcount != 16'hFFFF) r_mcount <= r_mcount + 16'd1;
      end
    end
  end

  bp_table #(
    .IDX_W (IDX_W)
  ) u_table (
    .stg_clk (stg_clk),
    .reset   (reset),
    .wr_en   (w_wr_en),
    .wr_idx  (bus.in_pc[IDX_W+1:2]),
    .wr_tag  (bus.in_pc[31:IDX_W+2]),
    .wr_cnt  (w_wr_cnt),
    .wr_tgt  (bus.in_target),
    .rd_idx  (bus.lookup_pc[IDX_W+1:2]),
    .rd_tag  (bus.lookup_pc[31:IDX_W+2]),
    .rd_hit  (w_rd_hit),
    .rd_cnt  (w_rd_cnt),
    .rd_tgt  (w_rd_tgt)
  );

  assign bus.lookup_valid      = w_rd_hit;
  assign bus.lookup_counter    = w_rd_cnt;
  assign bus.lookup_target     = w_rd_tgt;
  assign bus.lookup_prediction = w_rd_hit && w_rd_cnt[1];
  assign bus.flush             = r_flush;
  assign bus.redirect_pc       = r_redirect;
  assign bus.mispredict_count  = r_mcount;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
// Self-checking bench: directed vector table, hand-written reset/no-bypass
// sequences, randomized records against a behavioural model, and a
// saturation run on a second instance with no squash window.
module tb_branch_resolve_unit;

  logic stg_clk = 1'b0;
  logic reset   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 stg_clk = ~stg_clk;

  branch_resolve_unit_if ifA ();
  branch_resolve_unit_if ifB ();

  branch_resolve_unit #(.IDX_W(4), .FLUSH_DEPTH(2)) u_dut_a (
    .stg_clk (stg_clk),
    .reset   (reset),
    .bus     (ifA.slave)
  );

  branch_resolve_unit #(.IDX_W(4), .FLUSH_DEPTH(0)) u_dut_b (
    .stg_clk (stg_clk),
    .reset   (reset),
    .bus     (ifB.slave)
  );

  typedef struct {
    logic        ena;
    logic [1:0]  flag;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [1:0]  cnt;
    logic        vld;
    logic        pred;
    logic [31:0] lpc;
    logic        expFlush;
    logic [31:0] expRedirect;
    logic        expLv;
    logic [1:0]  expLc;
    logic [31:0] expLt;
    logic [15:0] expMc;
  } vector_t;

  vector_t vecs[15];

  function automatic vector_t mkVec(
    input logic ena, input logic [1:0] flag, input logic [31:0] pc, input logic [31:0] tgt,
    input logic [1:0] cnt, input logic vld, input logic pred, input logic [31:0] lpc,
    input logic eFlush, input logic [31:0] eRedir, input logic eLv, input logic [1:0] eLc,
    input logic [31:0] eLt, input logic [15:0] eMc);
    vector_t v;
    v.ena = ena; v.flag = flag; v.pc = pc; v.tgt = tgt; v.cnt = cnt; v.vld = vld;
    v.pred = pred; v.lpc = lpc; v.expFlush = eFlush; v.expRedirect = eRedir;
    v.expLv = eLv; v.expLc = eLc; v.expLt = eLt; v.expMc = eMc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    ifA.stg_ena       = v.ena;
    ifA.in_flag       = v.flag;
    ifA.in_pc         = v.pc;
    ifA.in_target     = v.tgt;
    ifA.in_counter    = v.cnt;
    ifA.in_valid      = v.vld;
    ifA.in_prediction = v.pred;
    ifA.lookup_pc     = v.lpc;
  endtask

  task automatic idleA();
    ifA.stg_ena = 1'b0; ifA.in_flag = 2'b00; ifA.in_pc = '0; ifA.in_target = '0;
    ifA.in_counter = 2'b01; ifA.in_valid = 1'b0; ifA.in_prediction = 1'b0;
  endtask

  // Leaves time at one unit past a rising edge with reset released
  task automatic resetDut();
    reset = 1'b0;
    idleA();
    repeat (2) @(posedge stg_clk);
    #1 reset = 1'b1;
  endtask

  // Behavioural model state for the randomized phase
  bit          mValid [16];
  logic [25:0] mTag   [16];
  int          mCnt   [16];
  logic [31:0] mTgt   [16];
  int          mSquash;
  int          mCount;

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin : main
    vector_t v;
    idleA();
    ifA.lookup_pc = 32'h100;
    ifB.stg_ena = 1'b0; ifB.in_flag = 2'b01; ifB.in_pc = 32'h200; ifB.in_target = 32'h300;
    ifB.in_counter = 2'b01; ifB.in_valid = 1'b0; ifB.in_prediction = 1'b0; ifB.lookup_pc = 32'h200;

    // Reset state
    repeat (2) @(posedge stg_clk);
    #1 reset = 1'b1;
    checkOutput("rst.lookup_valid", 32'(ifA.lookup_valid), 32'd0);
    checkOutput("rst.lookup_counter", 32'(ifA.lookup_counter), 32'd1);
    checkOutput("rst.flush", 32'(ifA.flush), 32'd0);
    checkOutput("rst.redirect_pc", ifA.redirect_pc, 32'd0);
    checkOutput("rst.mispredict_count", 32'(ifA.mispredict_count), 32'd0);

    // Directed table (FLUSH_DEPTH=2)
    //                ena flag   pc            tgt         cnt   vld   pred  lookup        flush redirect     lv    lc     lt          mc
    vecs[0]  = mkVec(1, 2'b01, 32'h100,      32'h200,     2'b01, 1'b0, 1'b0, 32'h100,      1, 32'h200,      1, 2'b10, 32'h200, 16'd1);
    vecs[1]  = mkVec(1, 2'b10, 32'h100,      32'h200,     2'b10, 1'b1, 1'b1, 32'h100,      0, 32'h0,        1, 2'b10, 32'h200, 16'd1);
    vecs[2]  = mkVec(1, 2'b01, 32'h140,      32'h900,     2'b01, 1'b0, 1'b0, 32'h140,      0, 32'h0,        0, 2'b10, 32'h200, 16'd1);
    vecs[3]  = mkVec(1, 2'b10, 32'h100,      32'h200,     2'b11, 1'b1, 1'b1, 32'h100,      1, 32'h104,      1, 2'b10, 32'h200, 16'd2);
    vecs[4]  = mkVec(0, 2'b01, 32'h100,      32'h200,     2'b01, 1'b0, 1'b0, 32'h100,      0, 32'h0,        1, 2'b10, 32'h200, 16'd2);
    vecs[5]  = mkVec(1, 2'b01, 32'h100,      32'h200,     2'b01, 1'b0, 1'b0, 32'h100,      0, 32'h0,        1, 2'b10, 32'h200, 16'd2);
    vecs[6]  = mkVec(1, 2'b01, 32'h100,      32'h200,     2'b01, 1'b0, 1'b0, 32'h100,      0, 32'h0,        1, 2'b10, 32'h200, 16'd2);
    vecs[7]  = mkVec(1, 2'b01, 32'h104,      32'h300,     2'b11, 1'b1, 1'b1, 32'h104,      0, 32'h0,        1, 2'b11, 32'h300, 16'd2);
    vecs[8]  = mkVec(1, 2'b10, 32'h108,      32'h400,     2'b00, 1'b1, 1'b0, 32'h108,      0, 32'h0,        1, 2'b00, 32'h400, 16'd2);
    vecs[9]  = mkVec(1, 2'b10, 32'h10C,      32'h480,     2'b01, 1'b0, 1'b0, 32'h10C,      0, 32'h0,        0, 2'b01, 32'h0,   16'd2);
    vecs[10] = mkVec(1, 2'b11, 32'h110,      32'h500,     2'b01, 1'b0, 1'b0, 32'h110,      1, 32'h500,      1, 2'b11, 32'h500, 16'd3);
    vecs[11] = mkVec(1, 2'b01, 32'h110,      32'h800,     2'b00, 1'b0, 1'b0, 32'h110,      0, 32'h0,        1, 2'b11, 32'h500, 16'd3);
    vecs[12] = mkVec(1, 2'b01, 32'h110,      32'h800,     2'b00, 1'b0, 1'b0, 32'h110,      0, 32'h0,        1, 2'b11, 32'h500, 16'd3);
    vecs[13] = mkVec(1, 2'b00, 32'h110,      32'h800,     2'b00, 1'b0, 1'b0, 32'h110,      0, 32'h0,        1, 2'b11, 32'h500, 16'd3);
    vecs[14] = mkVec(1, 2'b10, 32'hFFFFFFFC, 32'h600,     2'b10, 1'b1, 1'b1, 32'hFFFFFFFC, 1, 32'h0,        1, 2'b01, 32'h600, 16'd4);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      @(posedge stg_clk);
      #1;
      checkOutput($sformatf("v%0d.flush", i), 32'(ifA.flush), 32'(vecs[i].expFlush));
      if (vecs[i].expFlush)
        checkOutput($sformatf("v%0d.redirect_pc", i), ifA.redirect_pc, vecs[i].expRedirect);
      checkOutput($sformatf("v%0d.lookup_valid", i), 32'(ifA.lookup_valid), 32'(vecs[i].expLv));
      checkOutput($sformatf("v%0d.lookup_counter", i), 32'(ifA.lookup_counter), 32'(vecs[i].expLc));
      checkOutput($sformatf("v%0d.lookup_target", i), ifA.lookup_target, vecs[i].expLt);
      checkOutput($sformatf("v%0d.lookup_prediction", i), 32'(ifA.lookup_prediction),
                  32'(vecs[i].expLv & vecs[i].expLc[1]));
      checkOutput($sformatf("v%0d.mispredict_count", i), 32'(ifA.mispredict_count), 32'(vecs[i].expMc));
    end

    // Same-cycle write and lookup: lookup shows pre-write contents
    resetDut();
    v = mkVec(1, 2'b01, 32'h180, 32'hA00, 2'b01, 1'b0, 1'b0, 32'h180, 1, 32'hA00, 1, 2'b10, 32'hA00, 16'd1);
    applyStimulus(v);
    #1;
    checkOutput("nobypass.pre_valid", 32'(ifA.lookup_valid), 32'd0);
    @(posedge stg_clk);
    #1;
    checkOutput("nobypass.post_valid", 32'(ifA.lookup_valid), 32'd1);
    checkOutput("nobypass.flush", 32'(ifA.flush), 32'd1);

    // Asynchronous reset while flush is high and the unit is squashing
    #2 reset = 1'b0;
    idleA();
    #1;
    checkOutput("midrst.flush", 32'(ifA.flush), 32'd0);
    checkOutput("midrst.lookup_valid", 32'(ifA.lookup_valid), 32'd0);
    checkOutput("midrst.mispredict_count", 32'(ifA.mispredict_count), 32'd0);
    @(posedge stg_clk);
    #1 reset = 1'b1;
    v = mkVec(1, 2'b11, 32'h1C0, 32'h700, 2'b01, 1'b0, 1'b0, 32'h1C0, 1, 32'h700, 1, 2'b11, 32'h700, 16'd1);
    applyStimulus(v);
    @(posedge stg_clk);
    #1;
    checkOutput("midrst.next_flush", 32'(ifA.flush), 32'd1);
    checkOutput("midrst.next_redirect", ifA.redirect_pc, 32'h700);
    checkOutput("midrst.next_counter", 32'(ifA.lookup_counter), 32'd3);

    // Randomized records against the model
    resetDut();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0; mTag[i] = '0; mCnt[i] = 1; mTgt[i] = '0;
    end
    mSquash = 0;
    mCount  = 0;
    begin
      bit   prevFlush;
      prevFlush = 1'b0;
      for (int n = 0; n < 400; n++) begin
        logic [31:0] pc, lpc, tgt;
        int          idx, lidx, cnt;
        bit          ena, vld, pred, actual, mis, expHit;
        logic [1:0]  flag;
        logic [31:0] expRedirect;
        pc   = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
             : 32'h1000 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 15)) << 2);
        lpc  = ($urandom_range(0, 1) == 0) ? pc
             : 32'h1000 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 15)) << 2);
        tgt  = $urandom;
        ena  = ($urandom_range(0, 3) != 0);
        flag = 2'($urandom_range(0, 3));
        cnt  = $urandom_range(0, 3);
        vld  = $urandom_range(0, 1);
        pred = $urandom_range(0, 1);
        ifA.stg_ena = ena; ifA.in_flag = flag; ifA.in_pc = pc; ifA.in_target = tgt;
        ifA.in_counter = 2'(cnt); ifA.in_valid = vld; ifA.in_prediction = pred; ifA.lookup_pc = lpc;
        #1;
        lidx   = int'(lpc[5:2]);
        expHit = mValid[lidx] && (mTag[lidx] == lpc[31:6]);
        checkOutput("rnd.lookup_valid", 32'(ifA.lookup_valid), 32'(expHit));
        checkOutput("rnd.lookup_counter", 32'(ifA.lookup_counter), 32'(mCnt[lidx]));
        checkOutput("rnd.lookup_target", ifA.lookup_target, mTgt[lidx]);
        checkOutput("rnd.lookup_prediction", 32'(ifA.lookup_prediction), 32'(expHit && mCnt[lidx] >= 2));

        mis = 1'b0;
        expRedirect = '0;
        if (ena && mSquash > 0) begin
          mSquash = mSquash - 1;
        end else if (ena && flag != 2'b00) begin
          actual = (flag == 2'b01) || (flag == 2'b11);
          mis    = ((vld && pred) != actual);
          idx    = int'(pc[5:2]);
          if (mis) begin
            expRedirect = actual ? tgt : pc + 32'd4;
            mCount  = (mCount < 65535) ? mCount + 1 : 65535;
            mSquash = 2;
          end
          if (vld || actual) begin
            mValid[idx] = 1'b1;
            mTag[idx]   = pc[31:6];
            mTgt[idx]   = tgt;
            if (flag == 2'b11)  mCnt[idx] = 3;
            else if (!vld)      mCnt[idx] = 2;
            else if (actual)    mCnt[idx] = (cnt + 1 > 3) ? 3 : cnt + 1;
            else                mCnt[idx] = (cnt - 1 < 0) ? 0 : cnt - 1;
          end
        end
        @(posedge stg_clk);
        #1;
        checkOutput("rnd.flush", 32'(ifA.flush), 32'(mis));
        if (mis) checkOutput("rnd.redirect_pc", ifA.redirect_pc, expRedirect);
        checkOutput("rnd.mispredict_count", 32'(ifA.mispredict_count), 32'(mCount));
        checkOutput("rnd.flush_pair", 32'(prevFlush && ifA.flush), 32'd0);
        prevFlush = ifA.flush;
      end
    end
    idleA();

    // Saturation of the statistics counter, back-to-back mispredicts with no squash
    ifB.stg_ena = 1'b1;
    for (int k = 1; k <= 32'h10001; k++) begin
      @(posedge stg_clk);
      #1;
      if (k == 2) checkOutput("sat.flush_back_to_back", 32'(ifB.flush), 32'd1);
      if (k == 32'hFFFE) checkOutput("sat.count_fffe", 32'(ifB.mispredict_count), 32'hFFFE);
      if (k == 32'hFFFF) checkOutput("sat.count_ffff", 32'(ifB.mispredict_count), 32'hFFFF);
      if (k == 32'h10001) checkOutput("sat.count_held", 32'(ifB.mispredict_count), 32'hFFFF);
    end
    ifB.stg_ena = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Branch resolution and predictor-update stage sitting directly downstream of the A/D pipeline latch. Each stage-enabled cycle it consumes the latched branch record (PC, computed target, branch flag, predictor counter/valid/prediction captured at fetch), decides the real outcome, raises a one-cycle flush with the redirect PC on a misprediction, and writes the updated 2-bit counter and target back into a direct-mapped branch target table. The same table is read combinationally by fetch through a lookup port.

## Interface
Parameters:
- IDX_W, 4, table index width; ENTRIES = 2**IDX_W
- FLUSH_DEPTH, 2, number of stage-enabled cycles of wrong-path records squashed after a flush

Ports:
- stg_clk  in  1  stage clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- stg_ena  in  1  stage enable; records consumed only when high
- in_pc  in  32  branch instruction PC
- in_target  in  32  computed branch target
- in_flag  in  2  00 none, 01 cond taken, 10 cond not-taken, 11 unconditional jump
- in_counter  in  2  counter read at fetch
- in_valid  in  1  table hit at fetch
- in_prediction  in  1  taken prediction made at fetch
- lookup_pc  in  32  fetch PC
- lookup_valid  out  1  entry valid and tag match
- lookup_counter  out  2  stored counter
- lookup_target  out  32  stored target
- lookup_prediction  out  1  lookup_valid & lookup_counter[1]
- flush  out  1  one-cycle misprediction pulse
- redirect_pc  out  32  correct next PC, meaningful while flush=1
- mispredict_count  out  16  saturating misprediction counter

## Operation
- Entry: valid, tag = pc[31:IDX_W+2], counter[1:0], target[31:0]; index = pc[IDX_W+1:2].
- Record is live when stg_ena=1, in_flag!=00, state=RUN.
- actual_taken = (in_flag==01) | (in_flag==11); predicted = in_valid & in_prediction.
- Mispredict when predicted != actual_taken. On mispredict: flush=1, redirect_pc = actual_taken ? in_target : in_pc+4 (32-bit wrap), mispredict_count += 1 saturating at 0xFFFF, state -> SQUASH with count FLUSH_DEPTH.
- Table update on live record: in_valid=1: counter = sat_inc(in_counter) if taken else sat_dec(in_counter) (00/11 saturate), target=in_target, tag rewritten. in_valid=0 and taken: allocate, valid=1, counter=10, target, tag. in_valid=0 and not taken: no write. in_flag=11 always writes counter=11.
- Counter update uses carried in_counter, not current table contents.
- States: RUN (normal); SQUASH (each stg_ena cycle decrements count, records ignored entirely, no table write, no flush; count reaching 0 -> RUN). FLUSH_DEPTH=0 never enters SQUASH.
- Lookup is combinational; write and lookup to same index in one cycle returns pre-write contents (no bypass).
- stg_ena=0: no update, no flush, state and squash count hold.

## Timing
- Reset (reset=0, asynchronous): all valid=0, counters=01, tags/targets=0, flush=0, redirect_pc=0, mispredict_count=0, state=RUN. Reset mid-SQUASH returns to RUN.
- Latency: record on edge N -> flush/redirect_pc visible after edge N, deasserted after edge N+1; table write visible at lookup after edge N.
- flush never asserted two consecutive cycles (second record is in SQUASH).

## Structure
- Package bp_pkg: flag encodings (FLAG_NONE/TAKEN/NOT_TAKEN/JUMP), counter constants (CNT_SNT=00..CNT_ST=11, CNT_ALLOC=10, CNT_RESET=01), state enum RUN/SQUASH.
- One sub-module bp_table: entry storage, async-reset, one write port, one combinational read port with tag compare.

## Test plan
- Reset then lookup_pc=0x100 -> lookup_valid=0, flush=0, mispredict_count=0.
- Miss, in_flag=01, in_pc=0x100, target=0x200 -> flush=1 one cycle, redirect_pc=0x200; next lookup 0x100 -> valid=1, counter=10, target=0x200, prediction=1.
- Hit, in_counter=11, prediction=1, in_flag=10, pc=0x100 -> flush, redirect_pc=0x104, counter 10; next two stg_ena records (even mispredicting) ignored, third processed.
- Hit, in_counter=11, in_flag=01 predicted taken -> no flush, counter stays 11; in_counter=00 not-taken -> stays 00.
- 0x10000 back-to-back mispredicts with FLUSH_DEPTH=0 -> mispredict_count stops at 0xFFFF.
- Assert reset low during SQUASH with flush=1 -> flush=0, table invalid, next record processed as RUN.
